mod_counter_ud: RTL and testbench



---
 rtl/mod_counter_pkg.sv | 57 +++++
 rtl/sat_counter.sv | 25 ++
 rtl/mod_counter_ud.sv | 101 ++++++++++
 tb/tb_mod_counter_ud.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants and step-decode helper for the mod_counter_ud family.
// The MOD_COUNTER_WRAP_COUNT_EN build option lives in the top and sat_counter.
package mod_counter_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int WRAP_CNT_W = 8;

  // What the counter does on the coming edge, already prioritised.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC,
    ACT_CLAMP,
    ACT_WRAP,
    ACT_FINISH
  } step_act_e;

  // Reaching the terminal state either wraps or completes, depending on mode.
  function automatic step_act_e terminal_act(input logic mode);
    step_act_e act;
    act = ACT_WRAP;
    case (mode)
      MODE_ONESHOT: act = ACT_FINISH;
      MODE_WRAP:    act = ACT_WRAP;
      default:      act = ACT_WRAP;
    endcase
    return act;
  endfunction

  // Enabled-step decode from direction and range comparisons against modulus.
  function automatic step_act_e count_act(input logic up,
                                          input logic mode,
                                          input logic q_ge_mod,
                                          input logic q_gt_mod,
                                          input logic q_zero);
    step_act_e act;
    act = ACT_HOLD;
    case (up)
      DIR_UP:   act = q_ge_mod ? terminal_act(mode) : ACT_INC;
      DIR_DOWN: begin
        if (q_gt_mod)    act = ACT_CLAMP;
        else if (q_zero) act = terminal_act(mode);
        else             act = ACT_DEC;
      end
      default:  act = ACT_HOLD;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 8-bit saturating event counter with synchronous clear.
// Only built when MOD_COUNTER_WRAP_COUNT_EN is defined.
`ifdef MOD_COUNTER_WRAP_COUNT_EN
module sat_counter
  import mod_counter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [WRAP_CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WRAP_CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/mod_counter_ud.sv
// Parametrised up/down modulo counter with load, clear, wrap/one-shot mode.
// Define MOD_COUNTER_WRAP_COUNT_EN to add the saturating wrap_count output.
module mod_counter_ud
  import mod_counter_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic [WIDTH-1:0] modulus,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             rollover,
  output logic             done
`ifdef MOD_COUNTER_WRAP_COUNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  step_act_e        act;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic             rollover_nxt;

  // A completed one-shot ignores en entirely until clr or load.
  always_comb begin
    act = ACT_HOLD;
    if (clr) begin
      act = ACT_CLEAR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (en && !done) begin
      act = count_act(up, mode, (q >= modulus), (q > modulus), (q == '0));
    end
  end

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    q_nxt        = q;
    done_nxt     = done;
    rollover_nxt = 1'b0;
    case (act)
      ACT_CLEAR: begin
        q_nxt    = '0;
        done_nxt = 1'b0;
      end
      ACT_LOAD: begin
        q_nxt    = load_val;
        done_nxt = 1'b0;
      end
      ACT_INC:   q_nxt = q + STEP;
      ACT_DEC:   q_nxt = q - STEP;
      ACT_CLAMP: q_nxt = modulus;
      ACT_WRAP: begin
        q_nxt        = (up == DIR_UP) ? '0 : modulus;
        rollover_nxt = 1'b1;
      end
      ACT_FINISH: begin
        done_nxt     = 1'b1;
        rollover_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RESET_VAL;
      rollover <= 1'b0;
      done     <= 1'b0;
    end else begin
      q        <= q_nxt;
      rollover <= rollover_nxt;
      done     <= done_nxt;
    end
  end

`ifdef MOD_COUNTER_WRAP_COUNT_EN
  // Fed from rollover_nxt so the count lands on the same edge as the pulse.
  sat_counter u_wrap_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (rollover_nxt),
    .count (wrap_count)
  );
`endif

endmodule

// File: tb/tb_mod_counter_ud.sv
// Self-checking bench for mod_counter_ud: vector table, directed corner
// sequences and a randomized run against a rule-level reference model.
module tb_mod_counter_ud;
  import mod_counter_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, clr, load, up, mode;
  logic [W-1:0] load_val, modulus;
  logic [W-1:0] q;
  logic         rollover, done;
`ifdef MOD_COUNTER_WRAP_COUNT_EN
  logic [7:0]   wrap_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  int unsigned m_q, m_wc;
  bit          m_done, m_roll;

  always #5 clk = ~clk;

  mod_counter_ud #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .up         (up),
    .modulus    (modulus),
    .mode       (mode),
    .q          (q),
    .rollover   (rollover),
    .done       (done)
`ifdef MOD_COUNTER_WRAP_COUNT_EN
    ,
    .wrap_count (wrap_count)
`endif
  );

  typedef struct {
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         up;
    logic [W-1:0] modulus;
    logic         mode;
    logic [W-1:0] exp_q;
    logic         exp_roll;
    logic         exp_done;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic c, input logic l, input int lv,
                              input logic e, input logic u, input int m,
                              input logic md, input int eq, input logic er,
                              input logic ed);
    vec_t v;
    v.clr = c; v.load = l; v.load_val = W'(lv); v.en = e; v.up = u;
    v.modulus = W'(m); v.mode = md; v.exp_q = W'(eq); v.exp_roll = er;
    v.exp_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic u, input logic [W-1:0] m,
                       input logic md);
    clr = c; load = l; load_val = lv; en = e; up = u; modulus = m; mode = md;
  endtask

  // Outputs are sampled 1 ns after the edge, inputs changed at the same time.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies the counter rules to the currently driven inputs.
  task automatic model_edge();
    m_roll = 1'b0;
    if (clr) begin
      m_q = 0; m_done = 1'b0; m_wc = 0;
    end else if (load) begin
      m_q = load_val; m_done = 1'b0;
    end else if (en && !m_done) begin
      if (up) begin
        if (m_q < modulus) m_q = m_q + 1;
        else if (mode == MODE_WRAP) begin m_q = 0; m_roll = 1'b1; end
        else begin m_done = 1'b1; m_roll = 1'b1; end
      end else begin
        if (m_q > modulus) m_q = modulus;
        else if (m_q != 0) m_q = m_q - 1;
        else if (mode == MODE_WRAP) begin m_q = modulus; m_roll = 1'b1; end
        else begin m_done = 1'b1; m_roll = 1'b1; end
      end
    end
    if (m_roll && m_wc < 255) m_wc = m_wc + 1;
  endtask

  initial begin
    // Vector table: down wrap with out-of-range entry, then priority cases.
    vecs[0]  = mk(0, 1, 8,    1, 0, 5, 0, 8,    0, 0);
    vecs[1]  = mk(0, 0, 0,    1, 0, 5, 0, 5,    0, 0);
    vecs[2]  = mk(0, 0, 0,    1, 0, 5, 0, 4,    0, 0);
    vecs[3]  = mk(0, 0, 0,    1, 0, 5, 0, 3,    0, 0);
    vecs[4]  = mk(0, 0, 0,    1, 0, 5, 0, 2,    0, 0);
    vecs[5]  = mk(0, 0, 0,    1, 0, 5, 0, 1,    0, 0);
    vecs[6]  = mk(0, 0, 0,    1, 0, 5, 0, 0,    0, 0);
    vecs[7]  = mk(0, 0, 0,    1, 0, 5, 0, 5,    1, 0);
    vecs[8]  = mk(0, 0, 0,    1, 0, 5, 0, 4,    0, 0);
    vecs[9]  = mk(1, 1, 'hAA, 1, 0, 5, 0, 0,    0, 0);
    vecs[10] = mk(0, 1, 'hAA, 1, 0, 5, 0, 'hAA, 0, 0);
    vecs[11] = mk(0, 0, 0,    0, 1, 9, 0, 'hAA, 0, 0);
    vecs[12] = mk(0, 0, 0,    1, 1, 9, 0, 0,    1, 0);
    vecs[13] = mk(0, 0, 0,    1, 1, 9, 0, 1,    0, 0);
    vecs[14] = mk(0, 0, 0,    1, 1, 9, 1, 2,    0, 0);

    rst = 1'b1;
    drive(0, 0, '0, 0, 1, 16'hFFFF, MODE_WRAP);
    #1;
    check("reset_q", q, 0);
    check("reset_rollover", rollover, 0);
    check("reset_done", done, 0);
    tick();
    rst = 1'b0;

    // Asynchronous reset mid-count.
    drive(0, 1, 16'h1234, 0, 1, 16'hFFFF, MODE_WRAP);
    tick();
    check("load_1234", q, 32'h1234);
    drive(0, 0, '0, 1, 1, 16'hFFFF, MODE_WRAP);
    tick();
    check("count_1235", q, 32'h1235);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_roll", rollover, 0);
    check("async_rst_done", done, 0);
    tick();
    check("rst_held_q", q, 0);
    rst = 1'b0;
    tick();
    check("first_step_q", q, 1);

    // Table-driven vectors.
    drive(1, 0, '0, 0, 1, 16'hFFFF, MODE_WRAP);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en,
            vecs[i].up, vecs[i].modulus, vecs[i].mode);
      tick();
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_roll", i), rollover, vecs[i].exp_roll);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
    end

    // Up wrap, modulus 9: rollover exactly when q returns to 0.
    drive(1, 0, '0, 0, 1, 16'd9, MODE_WRAP);
    tick();
    drive(0, 0, '0, 1, 1, 16'd9, MODE_WRAP);
    for (int i = 1; i <= 25; i++) begin
      tick();
      check($sformatf("upwrap%0d_q", i), q, i % 10);
      check($sformatf("upwrap%0d_roll", i), rollover, (i % 10) == 0);
    end

    // One-shot up to 3: a single pulse when done rises, then frozen.
    drive(1, 0, '0, 0, 1, 16'd3, MODE_ONESHOT);
    tick();
    drive(0, 0, '0, 1, 1, 16'd3, MODE_ONESHOT);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("oneshot%0d_q", k), q, (k < 3) ? k : 3);
      check($sformatf("oneshot%0d_done", k), done, k >= 4);
      check($sformatf("oneshot%0d_roll", k), rollover, k == 4);
    end
    drive(1, 0, '0, 1, 1, 16'd3, MODE_ONESHOT);
    tick();
    check("oneshot_clr_q", q, 0);
    check("oneshot_clr_done", done, 0);

    // One-shot with modulus 0: first enabled edge completes.
    drive(0, 0, '0, 1, 0, 16'd0, MODE_ONESHOT);
    tick();
    check("os_mod0_done", done, 1);
    check("os_mod0_roll", rollover, 1);
    tick();
    check("os_mod0_roll_once", rollover, 0);
    check("os_mod0_q", q, 0);

    // Wrap with modulus 0: rollover every enabled cycle.
    drive(1, 0, '0, 1, 1, 16'd0, MODE_WRAP);
    tick();
    drive(0, 0, '0, 1, 1, 16'd0, MODE_WRAP);
    for (int i = 1; i <= 300; i++) begin
      tick();
      check($sformatf("mod0_%0d_roll", i), rollover, 1);
      check($sformatf("mod0_%0d_q", i), q, 0);
`ifdef MOD_COUNTER_WRAP_COUNT_EN
      check($sformatf("mod0_%0d_wc", i), wrap_count, (i < 255) ? i : 255);
`endif
    end
    drive(0, 1, 16'd3, 1, 1, 16'd0, MODE_WRAP);
    tick();
    check("mod0_load_q", q, 3);
    check("mod0_load_roll", rollover, 0);
`ifdef MOD_COUNTER_WRAP_COUNT_EN
    check("wc_kept_by_load", wrap_count, 255);
`endif
    drive(1, 0, '0, 1, 1, 16'd0, MODE_WRAP);
    tick();
    check("mod0_clr_q", q, 0);
`ifdef MOD_COUNTER_WRAP_COUNT_EN
    check("wc_cleared", wrap_count, 0);
`endif

    // Randomized run against the reference model, starting from a clear.
    m_q = 0; m_done = 1'b0; m_wc = 0; m_roll = 1'b0;
    begin
      logic [W-1:0] r_mod;
      logic         r_mode;
      r_mod  = 16'd7;
      r_mode = MODE_WRAP;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 4))
            0: r_mod = 16'd0;
            1: r_mod = 16'd1;
            2: r_mod = W'($urandom_range(2, 12));
            3: r_mod = 16'hFFFF;
            default: r_mod = W'($urandom);
          endcase
        end
        if ($urandom_range(0, 31) == 0) r_mode = ~r_mode;
        drive((i == 0) || ($urandom_range(0, 40) == 0),
              $urandom_range(0, 20) == 0,
              ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20))
                                          : W'($urandom),
              $urandom_range(0, 3) != 0,
              ($urandom_range(0, 3) != 0) ? DIR_UP : DIR_DOWN,
              r_mod, r_mode);
        model_edge();
        tick();
        check($sformatf("rand%0d_q", i), q, m_q);
        check($sformatf("rand%0d_roll", i), rollover, m_roll);
        check($sformatf("rand%0d_done", i), done, m_done);
`ifdef MOD_COUNTER_WRAP_COUNT_EN
        check($sformatf("rand%0d_wc", i), wrap_count, m_wc);
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
